// File: rtl/cache_bus_responder.sv
// Beat-serial line-fill / writeback responder for a cache controller,
// backed by a single-port beat-wide memory array.
module cache_bus_responder #(
    parameter int PA_BITS  = 32,
    parameter int LINELEN  = 512,
    parameter int BEATW    = 64,
    parameter int MEMBEATS = 4096,
    parameter int LATENCY  = 2,
    localparam int BEATS   = LINELEN / BEATW,
    localparam int LOGBWPL = $clog2(BEATS),
    localparam int MAW     = $clog2(MEMBEATS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         CacheBusRW,
    input  logic [PA_BITS-1:0] CacheBusAdr,
    input  logic [BEATW-1:0]   ReadDataWord,
    output logic               SelBusBeat,
    output logic [LOGBWPL-1:0] BeatCount,
    output logic [LINELEN-1:0] FetchBuffer,
    output logic               CacheBusAck,
    output logic               AdrErr,
    input  logic               MemWE,
    input  logic [MAW-1:0]     MemAdr,
    input  logic [BEATW-1:0]   MemWData
);

    localparam int OFFB   = $clog2(LINELEN / 8);
    localparam int NLINES = MEMBEATS / BEATS;
    localparam int LOGNL  = $clog2(NLINES);
    localparam int BASEW  = PA_BITS - OFFB;
    localparam int CMPW   = LOGNL + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;

    localparam logic [7:0] LAT_M1 = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

    logic [2:0]         r_state;
    logic [LOGNL-1:0]   r_line;
    logic               r_write;
    logic               r_oor;
    logic [7:0]         r_wcnt;
    logic [LOGBWPL-1:0] r_beat;
    logic [LINELEN-1:0] r_fetch;
    logic [BEATW-1:0]   r_mem [MEMBEATS];

    logic [BASEW-1:0]   w_base;
    logic [CMPW-1:0]    w_cmp;
    logic               w_hi;
    logic               w_oor;
    logic               w_req;
    logic               w_bd;
    logic               w_last;
    logic [MAW-1:0]     w_midx;
    logic               w_unused;

    assign w_base   = CacheBusAdr[PA_BITS-1:OFFB];
    assign w_unused = ^CacheBusAdr[OFFB-1:0];
    // High base bits are folded in so oversized addresses never alias low lines
    assign w_cmp  = w_base[CMPW-1:0];
    assign w_hi   = |w_base[BASEW-1:CMPW];
    assign w_oor  = w_hi | (w_cmp >= CMPW'(NLINES));
    assign w_req  = (r_state == S_IDLE) && (CacheBusRW != 2'b00);
    assign w_bd   = MemWE && (r_state == S_IDLE) && !w_req;
    assign w_last = (r_beat == LOGBWPL'(BEATS - 1));
    assign w_midx = {r_line, r_beat};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_line  <= '0;
            r_write <= 1'b0;
            r_oor   <= 1'b0;
            r_wcnt  <= '0;
            r_beat  <= '0;
            r_fetch <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_line  <= w_base[LOGNL-1:0];
                        r_write <= CacheBusRW[0];
                        r_oor   <= w_oor;
                        r_beat  <= '0;
                        r_wcnt  <= LAT_M1;
                        if (LATENCY > 0)
                            r_state <= S_WAIT;
                        else
                            r_state <= CacheBusRW[0] ? S_WRITE : S_READ;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == 8'd0)
                        r_state <= r_write ? S_WRITE : S_READ;
                    else
                        r_wcnt <= r_wcnt - 8'd1;
                end
                S_READ: begin
                    r_fetch[r_beat*BEATW +: BEATW] <= r_oor ? '0 : r_mem[w_midx];
                    r_beat <= r_beat + 1'b1;
                    if (w_last)
                        r_state <= S_ACK;
                end
                S_WRITE: begin
                    r_beat <= r_beat + 1'b1;
                    if (w_last)
                        r_state <= S_ACK;
                end
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Storage is never cleared; a beat sampled with reset low is not written
    always_ff @(posedge clk) begin
        if (reset) begin
            if (r_state == S_WRITE && !r_oor)
                r_mem[w_midx] <= ReadDataWord;
            else if (w_bd)
                r_mem[MemAdr] <= MemWData;
        end
    end

    assign SelBusBeat  = (r_state == S_WRITE);
    assign BeatCount   = r_beat;
    assign FetchBuffer = r_fetch;
    assign CacheBusAck = (r_state == S_ACK);
    assign AdrErr      = (r_state == S_ACK) && r_oor;

endmodule

// File: tb/tb_cache_bus_responder.sv
// Directed bench for cache_bus_responder with a scoreboard of expected
// line/ack results; also covers a zero-latency build.
module tb_cache_bus_responder;

    localparam int NL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [1:0]   rw;
    logic [31:0]  adr;
    logic [63:0]  rdw;
    logic         sel;
    logic [2:0]   bc;
    logic [511:0] fb;
    logic         ack;
    logic         aerr;
    logic         we;
    logic [5:0]   madr;
    logic [63:0]  mwd;
    logic [63:0]  wb_base;

    logic [1:0]   rw0;
    logic [31:0]  adr0;
    logic [63:0]  rdw0;
    logic         sel0;
    logic [2:0]   bc0;
    logic [511:0] fb0;
    logic         ack0;
    logic         aerr0;
    logic         we0;
    logic [5:0]   madr0;
    logic [63:0]  mwd0;

    always_comb rdw = wb_base + 64'(bc);
    assign rdw0 = 64'h0;

    cache_bus_responder #(.MEMBEATS(64), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .CacheBusRW(rw), .CacheBusAdr(adr),
        .ReadDataWord(rdw), .SelBusBeat(sel), .BeatCount(bc),
        .FetchBuffer(fb), .CacheBusAck(ack), .AdrErr(aerr),
        .MemWE(we), .MemAdr(madr), .MemWData(mwd)
    );

    cache_bus_responder #(.MEMBEATS(64), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .CacheBusRW(rw0), .CacheBusAdr(adr0),
        .ReadDataWord(rdw0), .SelBusBeat(sel0), .BeatCount(bc0),
        .FetchBuffer(fb0), .CacheBusAck(ack0), .AdrErr(aerr0),
        .MemWE(we0), .MemAdr(madr0), .MemWData(mwd0)
    );

    typedef struct {
        logic [511:0] line;
        logic         aerr;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    logic [63:0]  mdl [64];
    logic [511:0] mdl_fb;
    int tests = 0;
    int fails = 0;
    int sf, sl, n;
    bit found, seen;
    logic [511:0] exp0;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd(input int a, input logic [63:0] d);
        we   = 1'b1;
        madr = 6'(a);
        mwd  = d;
        mdl[a] = d;
        tick();
        we = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [1:0] rw_i,
                       input int line, input int drop_at, input bit b2b,
                       output int f, output int l);
        exp_t e;
        int   k;
        int   cnt;
        bit   done;
        bit   oor;
        oor = (line >= NL);
        if (rw_i == 2'b10) begin
            for (k = 0; k < 8; k++)
                e.line[k*64 +: 64] = oor ? 64'h0 : mdl[line*8+k];
            mdl_fb = e.line;
        end else begin
            if (!oor)
                for (k = 0; k < 8; k++)
                    mdl[line*8+k] = wb_base + 64'(k);
            e.line = mdl_fb;
        end
        e.aerr = oor;
        e.lat  = b2b ? 12 : 11;
        sb.push_back(e);
        rw  = rw_i;
        adr = (32'(line) << 6) | 32'h15;
        cnt = 0;
        f = -1;
        l = -1;
        done = 1'b0;
        while (!done && cnt < 40) begin
            tick();
            cnt++;
            if (cnt == drop_at) rw = 2'b00;
            if (sel) begin
                if (f < 0) f = cnt;
                l = cnt;
            end
            if (ack) done = 1'b1;
        end
        rw = 2'b00;
        chk({tag, "_ackseen"}, 512'(done), 512'(1));
        e = sb.pop_front();
        if (done) begin
            chk({tag, "_lat"}, 512'(cnt), 512'(e.lat));
            chk({tag, "_fb"}, fb, e.line);
            chk({tag, "_aerr"}, 512'(aerr), 512'(e.aerr));
            chk({tag, "_bc"}, 512'(bc), 512'(0));
        end
    endtask

    initial begin
        reset = 1'b0;
        rw = 2'b00; adr = '0; wb_base = '0;
        we = 1'b0; madr = '0; mwd = '0;
        rw0 = 2'b00; adr0 = '0; we0 = 1'b0; madr0 = '0; mwd0 = '0;
        mdl_fb = '0;
        repeat (3) tick();
        chk("rst_ack", 512'(ack), 512'(0));
        chk("rst_aerr", 512'(aerr), 512'(0));
        chk("rst_sel", 512'(sel), 512'(0));
        chk("rst_bc", 512'(bc), 512'(0));
        chk("rst_fb", fb, 512'(0));
        reset = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) bd(8 + k, 64'h1000 + 64'(k));
        txn("f1", 2'b10, 1, -1, 1'b0, sf, sl);
        chk("f1_b6", 512'(fb[6*64 +: 64]), 512'(64'h1006));
        tick();

        wb_base = 64'hA0;
        txn("wb3", 2'b01, 3, -1, 1'b0, sf, sl);
        chk("wb3_selfirst", 512'(sf), 512'(3));
        chk("wb3_sellast", 512'(sl), 512'(10));
        txn("f3", 2'b10, 3, -1, 1'b1, sf, sl);
        chk("f3_b5", 512'(fb[5*64 +: 64]), 512'(64'hA5));
        tick();

        for (int k = 0; k < 8; k++) bd(k, 64'h7000 + 64'(k));
        txn("foor", 2'b10, NL, -1, 1'b0, sf, sl);
        tick();
        wb_base = 64'hBB;
        txn("woor", 2'b01, NL, -1, 1'b0, sf, sl);
        tick();
        txn("f0", 2'b10, 0, -1, 1'b0, sf, sl);
        chk("f0_b0", 512'(fb[63:0]), 512'(64'h7000));
        tick();

        txn("drop", 2'b10, 1, 4, 1'b0, sf, sl);
        tick();
        wb_base = 64'hC0;
        txn("w11", 2'b11, 4, -1, 1'b0, sf, sl);
        chk("w11_sel", 512'(sf), 512'(3));
        tick();
        txn("f4", 2'b10, 4, -1, 1'b0, sf, sl);
        tick();

        for (int k = 0; k < 8; k++) bd(16 + k, 64'h2000 + 64'(k));
        wb_base = 64'h500;
        rw  = 2'b01;
        adr = 32'(2) << 6;
        found = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            tick();
            n++;
            if (sel && bc == 3'd4) found = 1'b1;
        end
        chk("rstmid_reach", 512'(found), 512'(1));
        reset = 1'b0;
        rw = 2'b00;
        tick();
        chk("rstmid_sel", 512'(sel), 512'(0));
        chk("rstmid_bc", 512'(bc), 512'(0));
        reset = 1'b1;
        seen = ack;
        repeat (3) begin
            tick();
            seen = seen | ack;
        end
        chk("rstmid_noack", 512'(seen), 512'(0));
        for (int k = 0; k < 4; k++) mdl[16 + k] = 64'h500 + 64'(k);
        txn("frst", 2'b10, 2, -1, 1'b0, sf, sl);
        chk("frst_b3", 512'(fb[3*64 +: 64]), 512'(64'h503));
        chk("frst_b4", 512'(fb[4*64 +: 64]), 512'(64'h2004));
        tick();

        for (int k = 0; k < 8; k++) begin
            we0 = 1'b1;
            madr0 = 6'(8 + k);
            mwd0 = 64'h3000 + 64'(k);
            exp0[k*64 +: 64] = 64'h3000 + 64'(k);
            tick();
        end
        we0 = 1'b0;
        rw0 = 2'b10;
        adr0 = 32'(1) << 6;
        n = 0;
        found = 1'b0;
        while (!found && n < 30) begin
            tick();
            n++;
            if (ack0) found = 1'b1;
        end
        rw0 = 2'b00;
        chk("l0_ackseen", 512'(found), 512'(1));
        chk("l0_lat", 512'(n), 512'(9));
        chk("l0_fb", fb0, exp0);
        chk("l0_bc", 512'(bc0), 512'(0));
        chk("l0_aerr", 512'(aerr0), 512'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
